// File: rtl/lcd_cmd_sequencer_pkg.sv
// rtl/lcd_cmd_sequencer_pkg.sv - HD44780 opcodes, FSM states, results and init ROM
package lcd_cmd_sequencer_pkg;

  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_HOME       = 8'h02;
  localparam logic [7:0] OP_ENTRY_INC  = 8'h06;
  localparam logic [7:0] OP_DISP_OFF   = 8'h08;
  localparam logic [7:0] OP_DISP_ON    = 8'h0C;
  localparam logic [7:0] OP_CURSOR_ON  = 8'h0E;
  localparam logic [7:0] OP_SHIFT_L    = 8'h10;
  localparam logic [7:0] OP_SHIFT_R    = 8'h14;
  localparam logic [7:0] OP_FUNC_4B1L  = 8'h20;
  localparam logic [7:0] OP_WRITE_CHAR = 8'h25;
  localparam logic [7:0] OP_FUNC_4B2L  = 8'h28;
  localparam logic [7:0] OP_FUNC_8B1L  = 8'h30;
  localparam logic [7:0] OP_FUNC_8B2L  = 8'h38;

  localparam logic [31:0] RESULT_OK    = 32'h0000_0000;
  localparam logic [31:0] RESULT_BADOP = 32'hFFFF_FFFF;

  localparam int INIT_LEN = 6;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_EXEC,
    S_DONE
  } state_t;

  // 8-bit, 2-line, display on, clear, entry increment
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = OP_FUNC_8B2L;
      3'd3:             init_rom = OP_DISP_ON;
      3'd4:             init_rom = OP_CLEAR;
      default:          init_rom = OP_ENTRY_INC;
    endcase
  endfunction

  function automatic logic is_supported(input logic [7:0] op);
    case (op)
      OP_CLEAR, OP_HOME, OP_DISP_OFF, OP_DISP_ON, OP_CURSOR_ON, OP_SHIFT_L,
      OP_SHIFT_R, OP_FUNC_4B1L, OP_FUNC_4B2L, OP_FUNC_8B1L, OP_FUNC_8B2L,
      OP_WRITE_CHAR: is_supported = 1'b1;
      default:       is_supported = 1'b0;
    endcase
  endfunction

  // Clear and home need the long execution wait
  function automatic logic is_slow_cmd(input logic [7:0] op);
    is_slow_cmd = (op == OP_CLEAR) || (op == OP_HOME);
  endfunction

  function automatic logic [7:0] bus_byte(input logic [7:0] op, input logic [7:0] chr);
    bus_byte = (op == OP_WRITE_CHAR) ? chr : op;
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_delay_timer.sv
// rtl/lcd_cmd_sequencer_delay_timer.sv - load/decrement delay counter with zero flag
module lcd_cmd_sequencer_delay_timer #(
  parameter int              CNT_W   = 20,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Reset value preloads the power-up wait so PWR_WAIT needs no entry load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= RST_VAL;
    end else if (clk_en) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - Nios II custom instruction driving an HD44780 LCD in 8-bit mode
module lcd_cmd_sequencer
  import lcd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned T_SETUP   = 3,
  parameter int unsigned T_EN      = 12,
  parameter int unsigned T_HOLD    = 3,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_POWERUP = 750000,
  parameter int          CNT_W     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_backlight
);

  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN      = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);

  state_t           state;
  logic [2:0]       init_idx;
  logic             in_init;
  logic             pend;
  logic [7:0]       pend_op;
  logic [7:0]       pend_chr;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             last_entry;
  logic             svc_valid;
  logic [7:0]       svc_op;
  logic [7:0]       svc_chr;
  logic             unused_bits;

  assign unused_bits = ^{dataa[31:8], datab[31:8]};
  assign lcd_rw      = 1'b0;
  assign last_entry  = (init_idx == 3'(INIT_LEN - 1));

  // A start arriving on the very cycle init finishes is serviced directly
  assign svc_valid = pend || start;
  assign svc_op    = start ? dataa[7:0] : pend_op;
  assign svc_chr   = start ? datab[7:0] : pend_chr;

  lcd_cmd_sequencer_delay_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_POWERUP)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer reloads on every state entry that needs a fresh delay
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LD_SETUP;
    case (state)
      S_INIT:  tmr_load = 1'b1;
      S_IDLE:  tmr_load = start && is_supported(dataa[7:0]);
      S_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_EN;
      end
      S_EN_HI: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_HOLD;
      end
      S_HOLD: begin
        tmr_load = tmr_zero;
        tmr_val  = (!lcd_rs && is_slow_cmd(lcd_data)) ? LD_CLEAR : LD_EXEC;
      end
      S_EXEC:  tmr_load = tmr_zero && in_init && last_entry && svc_valid && is_supported(svc_op);
      default: tmr_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_PWR_WAIT;
      init_idx      <= '0;
      in_init       <= 1'b1;
      pend          <= 1'b0;
      pend_op       <= '0;
      pend_chr      <= '0;
      done          <= 1'b0;
      result        <= '0;
      lcd_data      <= '0;
      lcd_rs        <= 1'b0;
      lcd_en        <= 1'b0;
      lcd_backlight <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (start && in_init) begin
        pend     <= 1'b1;
        pend_op  <= dataa[7:0];
        pend_chr <= datab[7:0];
      end
      case (state)
        S_PWR_WAIT: if (tmr_zero) state <= S_INIT;
        S_INIT: begin
          lcd_data <= init_rom(init_idx);
          lcd_rs   <= 1'b0;
          state    <= S_SETUP;
        end
        S_IDLE: begin
          if (start) begin
            if (is_supported(dataa[7:0])) begin
              lcd_data <= bus_byte(dataa[7:0], datab[7:0]);
              lcd_rs   <= (dataa[7:0] == OP_WRITE_CHAR);
              state    <= S_SETUP;
            end else begin
              done   <= 1'b1;
              result <= RESULT_BADOP;
            end
          end
        end
        S_SETUP: begin
          if (tmr_zero) begin
            lcd_en <= 1'b1;
            state  <= S_EN_HI;
          end
        end
        S_EN_HI: begin
          if (tmr_zero) begin
            lcd_en <= 1'b0;
            state  <= S_HOLD;
          end
        end
        S_HOLD: if (tmr_zero) state <= S_EXEC;
        S_EXEC: begin
          if (tmr_zero) begin
            if (!in_init) begin
              done   <= 1'b1;
              result <= RESULT_OK;
              state  <= S_DONE;
            end else if (!last_entry) begin
              init_idx <= init_idx + 3'd1;
              state    <= S_INIT;
            end else begin
              in_init       <= 1'b0;
              init_idx      <= '0;
              lcd_backlight <= 1'b1;
              pend          <= 1'b0;
              state         <= S_IDLE;
              if (svc_valid) begin
                if (is_supported(svc_op)) begin
                  lcd_data <= bus_byte(svc_op, svc_chr);
                  lcd_rs   <= (svc_op == OP_WRITE_CHAR);
                  state    <= S_SETUP;
                end else begin
                  done   <= 1'b1;
                  result <= RESULT_BADOP;
                end
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_PWR_WAIT;
      endcase
    end
  end

endmodule
